// File: rtl/instr_sequencer_if.sv
// Fetch and register-file signal bundle between the sequencer (master) and the
// instruction memory / register file (slave).
interface instr_sequencer_if;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [1:0] rf_read_reg1;
    logic [1:0] rf_read_reg2;
    logic [7:0] rf_read_data1;
    logic [7:0] rf_read_data2;
    logic       rf_write;
    logic [1:0] rf_write_reg;
    logic [7:0] rf_write_data;

    modport master (
        output imem_req, imem_addr, rf_read_reg1, rf_read_reg2,
               rf_write, rf_write_reg, rf_write_data,
        input  imem_ack, imem_data, rf_read_data1, rf_read_data2
    );

    modport slave (
        input  imem_req, imem_addr, rf_read_reg1, rf_read_reg2,
               rf_write, rf_write_reg, rf_write_data,
        output imem_ack, imem_data, rf_read_data1, rf_read_data2
    );
endinterface

// File: rtl/instr_sequencer.sv
// Four-state fetch/decode/read/writeback sequencer for an 8-bit ADD/LI/SUB/JMP ISA.
// Define SEQ_JUMP_EN to make opcode 11 a relative jump; otherwise it is a NOP.
//
// state    | meaning
// FETCH    | imem_req high, waiting for imem_ack; latch instruction
// DECODE   | drive rs/rt read selects; LI result formed; JMP/NOP retire here
// READ     | register-file data valid; ADD/SUB result registered
// WB       | one-cycle rf_write strobe; pc advances, instruction retires
module instr_sequencer (
    input  logic                clk,
    input  logic                reset,
    instr_sequencer_if.master   bus,
    output logic [7:0]          pc,
    output logic [7:0]          retired
);
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_READ, S_WB} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LI  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    state_t     state_q, state_d;
    logic       run_q;
    logic [7:0] pc_q, pc_d;
    logic [7:0] retired_q, retired_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] result_q, result_d;

    logic [1:0] opcode;
    logic [7:0] li_imm;
    assign opcode = ir_q[7:6];
    assign li_imm = {{4{ir_q[3]}}, ir_q[3:0]};

`ifdef SEQ_JUMP_EN
    logic [7:0] jmp_off;
    assign jmp_off = {{2{ir_q[5]}}, ir_q[5:0]};
`endif

    // run_q keeps imem_req low for the first cycle out of reset even though
    // the state register already reads FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            run_q     <= 1'b0;
            pc_q      <= 8'h00;
            retired_q <= 8'h00;
            ir_q      <= 8'h00;
            result_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            ir_q      <= ir_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ir_d      = ir_q;
        result_d  = result_q;
        unique case (state_q)
            S_FETCH: begin
                if (run_q && bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    state_d = S_READ;
                end else if (opcode == OP_LI) begin
                    result_d = li_imm;
                    state_d  = S_WB;
                end else begin
`ifdef SEQ_JUMP_EN
                    pc_d = pc_q + jmp_off;
`else
                    pc_d = pc_q + 8'd1;
`endif
                    retired_d = retired_q + 8'd1;
                    state_d   = S_FETCH;
                end
            end
            S_READ: begin
                if (opcode == OP_SUB) begin
                    result_d = bus.rf_read_data1 - bus.rf_read_data2;
                end else begin
                    result_d = bus.rf_read_data1 + bus.rf_read_data2;
                end
                state_d = S_WB;
            end
            S_WB: begin
                pc_d      = pc_q + 8'd1;
                retired_d = retired_q + 8'd1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.imem_req      = 1'b0;
        bus.imem_addr     = pc_q;
        bus.rf_read_reg1  = ir_q[5:4];
        bus.rf_read_reg2  = ir_q[3:2];
        bus.rf_write      = 1'b0;
        bus.rf_write_reg  = 2'b00;
        bus.rf_write_data = 8'h00;
        if (state_q == S_FETCH) begin
            bus.imem_req = run_q;
        end
        if (state_q == S_WB) begin
            bus.rf_write      = 1'b1;
            bus.rf_write_reg  = (opcode == OP_LI) ? ir_q[5:4] : ir_q[1:0];
            bus.rf_write_data = result_q;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed ISA cases plus random instruction streams
// checked against an instruction-level model of registers, pc and retire count.
module tb_instr_sequencer;
`ifdef SEQ_JUMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rf   [4];
    logic [7:0] mreg [4];
    logic [7:0] m_pc;
    logic [7:0] m_ret;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pc      (pc),
        .retired (retired)
    );

    always #5 clk = ~clk;

    // Register file with one-cycle registered read latency.
    always @(posedge clk) begin
        bus.rf_read_data1 <= rf[bus.rf_read_reg1];
        bus.rf_read_data2 <= rf[bus.rf_read_reg2];
        if (bus.rf_write === 1'b1) rf[bus.rf_write_reg] <= bus.rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch one instruction after dly wait cycles, then follow it until the
    // sequencer requests again; compare against the instruction-level model.
    task automatic do_instr(input logic [7:0] ins, input int dly, input bit decode_poke);
        logic [1:0] op;
        bit         exp_wr;
        logic [1:0] exp_rd;
        logic [7:0] exp_data;
        int         exp_lat, k, n_wr, wr_k;
        logic [1:0] got_rd;
        logic [7:0] got_data;
        op = ins[7:6];
        exp_wr = 1'b1;
        exp_rd = ins[1:0];
        exp_data = 8'h00;
        exp_lat = 3;
        got_rd = 2'b00;
        got_data = 8'h00;
        case (op)
            2'b00: exp_data = mreg[ins[5:4]] + mreg[ins[3:2]];
            2'b10: exp_data = mreg[ins[5:4]] - mreg[ins[3:2]];
            2'b01: begin
                exp_rd   = ins[5:4];
                exp_data = {{4{ins[3]}}, ins[3:0]};
                exp_lat  = 2;
            end
            default: begin
                exp_wr  = 1'b0;
                exp_lat = 1;
            end
        endcase

        chk("fetch_req", bus.imem_req, 1);
        chk("fetch_addr", bus.imem_addr, m_pc);
        repeat (dly) begin
            @(negedge clk);
            chk("fetch_hold", {bus.imem_req, bus.imem_addr}, {1'b1, m_pc});
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = ins;
        @(negedge clk);
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'($urandom);
        chk("decode_req", bus.imem_req, 0);
        if (decode_poke) bus.imem_ack = 1'b1;

        k = 1;
        n_wr = 0;
        wr_k = 0;
        while (bus.imem_req !== 1'b1 && k < 8) begin
            if (bus.rf_write === 1'b1) begin
                n_wr++;
                wr_k     = k;
                got_rd   = bus.rf_write_reg;
                got_data = bus.rf_write_data;
            end
            @(negedge clk);
            bus.imem_ack = 1'b0;
            k++;
        end
        bus.imem_ack = 1'b0;
        chk("return_cycle", k, exp_lat + 1);
        chk("write_count", n_wr, {31'd0, exp_wr});
        if (exp_wr) begin
            chk("write_cycle", wr_k, exp_lat);
            chk("write_reg", got_rd, exp_rd);
            chk("write_data", got_data, exp_data);
            mreg[exp_rd] = exp_data;
        end

        if (op == 2'b11 && JMP_EN) m_pc = m_pc + {{2{ins[5]}}, ins[5:0]};
        else                       m_pc = m_pc + 8'd1;
        m_ret = m_ret + 8'd1;
        chk("pc", pc, m_pc);
        chk("next_addr", bus.imem_addr, m_pc);
        chk("retired", retired, m_ret);
    endtask

    initial begin
        logic [7:0] ins;
        logic [7:0] old_r2;

        rf   = '{8'h3C, 8'h81, 8'h5A, 8'hE7};
        mreg = '{8'h3C, 8'h81, 8'h5A, 8'hE7};
        m_pc  = 8'h00;
        m_ret = 8'h00;
        reset = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_write", bus.rf_write, 0);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_wdata", {bus.rf_write_reg, bus.rf_write_data}, 0);
        chk("rst_rsel", {bus.rf_read_reg1, bus.rf_read_reg2}, 0);

        reset = 1'b1;
        #1 chk("release_req_pre_edge", bus.imem_req, 0);
        @(negedge clk);
        chk("release_req", bus.imem_req, 1);
        chk("release_addr", bus.imem_addr, 0);

        do_instr(8'h47, 2, 1'b0);
        chk("li_r0_7", rf[0], 8'h07);
        do_instr(8'h5F, 0, 1'b0);
        chk("li_r1_m1", rf[1], 8'hFF);
        do_instr(8'h16, 1, 1'b0);
        chk("add_r2", rf[2], 8'hFE);
        do_instr(8'h40, 0, 1'b0);
        do_instr(8'h51, 0, 1'b0);
        do_instr(8'hFE, 1, 1'b0);
        chk("jmp_target", bus.imem_addr, JMP_EN ? 8'd3 : 8'd6);
        do_instr(8'h87, 0, 1'b0);
        chk("sub_r3", rf[3], 8'hFF);
        do_instr(8'h4A, 4, 1'b1);

        for (int i = 0; i < 300; i++) begin
            do_instr(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 256 && m_pc != 8'hFF; i++) begin
            ins = 8'($urandom);
            ins[7:6] = 2'b01;
            do_instr(ins, 0, 1'b0);
        end
        chk("pc_at_255", pc, 8'hFF);
        do_instr(8'h16, 0, 1'b0);
        chk("pc_wrap", pc, 8'h00);

        // Assert reset while the LI r2 writeback strobe is high.
        old_r2 = rf[2];
        ins = {2'b01, 2'b10, old_r2[3:0] ^ 4'h1};
        chk("midwb_fetch_req", bus.imem_req, 1);
        bus.imem_ack  = 1'b1;
        bus.imem_data = ins;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("midwb_write_high", bus.rf_write, 1);
        #2 reset = 1'b0;
        #1;
        chk("midwb_write_drop", bus.rf_write, 0);
        chk("midwb_pc", pc, 0);
        chk("midwb_retired", retired, 0);
        chk("midwb_req", bus.imem_req, 0);
        @(posedge clk);
        #1 chk("midwb_no_write", rf[2], old_r2);
        @(negedge clk);
        reset = 1'b1;
        m_pc  = 8'h00;
        m_ret = 8'h00;
        @(negedge clk);
        chk("rerelease_req", bus.imem_req, 1);
        chk("rerelease_addr", bus.imem_addr, 0);
        do_instr(8'h2D, 1, 1'b0);
        do_instr(8'hC3, 0, 1'b1);
        do_instr(8'h9B, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Clock and reset SHALL be one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-004 imem_req  output  1  instruction fetch request.
REQ-005 imem_addr  output  8  fetch address; equals pc.
REQ-006 imem_ack  input  1  fetch acknowledge; imem_data valid in the same cycle.
REQ-007 imem_data  input  8  instruction byte.
REQ-008 rf_read_reg1 / rf_read_reg2  output  2 each  register-file read selects.
REQ-009 rf_read_data1 / rf_read_data2  input  8 each  register-file read data; one-cycle registered latency after a select.
REQ-010 rf_write  output  1  register-file write strobe.
REQ-011 rf_write_reg  output  2  write select.
REQ-012 rf_write_data  output  8  write data.
REQ-013 pc  output  8  current program counter.
REQ-014 retired  output  8  count of completed instructions; wraps 255 -> 0.

Function
REQ-015 Instruction format SHALL be [7:6] opcode: 00 ADD rd=rs+rt; 01 LI rd=sext(imm4); 10 SUB rd=rs-rt; 11 JMP pc=pc+sext(imm6).
REQ-016 Field mapping SHALL be: ADD/SUB rs=[5:4], rt=[3:2], rd=[1:0]; LI rd=[5:4], imm4=[3:0]; JMP imm6=[5:0].
REQ-017 The FSM SHALL have states FETCH, DECODE, READ, WB.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold pc stable until imem_ack is sampled 1 on a rising edge.
REQ-019 On that edge, imem_data SHALL be latched into the instruction register and the FSM SHALL move to DECODE; imem_req SHALL be 0 from DECODE onward.
REQ-020 imem_ack sampled while imem_req=0 SHALL be ignored.
REQ-021 In DECODE, rf_read_reg1=rs and rf_read_reg2=rt SHALL be driven from the instruction register. Next state: ADD/SUB -> READ; LI -> WB; JMP -> FETCH.
REQ-022 In READ, rf_read_data1/2 SHALL be used as operands; the 8-bit result SHALL be registered modulo 256 with carry/borrow discarded; next state WB.
REQ-023 In WB, rf_write SHALL be 1 for exactly one cycle with rf_write_reg=rd and rf_write_data=result; next state FETCH.
REQ-024 On leaving WB, pc SHALL become pc+1, wrapping 255 -> 0.
REQ-025 On leaving DECODE for JMP, pc SHALL become pc+sext(imm6) modulo 256. JMP offset 0 SHALL refetch the same address.
REQ-026 retired SHALL increment by 1 on each WB->FETCH and JMP DECODE->FETCH transition.
REQ-027 rf_write SHALL be 0 in every state other than WB.
REQ-028 Instruction latency SHALL be: ADD/SUB 3 cycles after ack; LI 2; JMP 1.

Reset
REQ-029 While reset=0, the block SHALL hold: state=FETCH, pc=0, retired=0, instruction register=0, result=0, and all outputs 0 including imem_req and rf_write.
REQ-030 Assertion of reset SHALL take effect immediately, without a clock edge, from any state. A pending fetch SHALL be abandoned and a WB write SHALL be suppressed.
REQ-031 On the first rising edge after reset deasserts, imem_req SHALL go to 1 with imem_addr=0.

Configuration
REQ-032 With macro SEQ_JUMP_EN defined, opcode 11 SHALL behave per REQ-025.
REQ-033 Without SEQ_JUMP_EN, opcode 11 SHALL be a NOP: DECODE -> FETCH, pc=pc+1, retired increments, no register write.

Verification
REQ-034 Reset release; ack at cycle 3 with 0x47 (LI r0,7) -> rf_write pulse with reg=0, data=0x07; pc=1; retired=1.
REQ-035 LI r1,-1 (0x5F) -> write data 0xFF. Then ADD r2=r1+r1 (0x16) with rf_read_data1=rf_read_data2=0xFF -> write reg 2, data 0xFE; write occurs 3 cycles after ack.
REQ-036 SUB r3=r0-r1 (0x87) with operands 0x00 and 0x01 -> write data 0xFF. pc=255 followed by any non-JMP instruction -> pc=0.
REQ-037 JMP -2 (0xFE) at pc=5 with SEQ_JUMP_EN -> next imem_addr=3 and no rf_write. Without SEQ_JUMP_EN -> next imem_addr=6.
REQ-038 Ack delayed 4 cycles -> imem_req and imem_addr stay stable throughout. Ack pulsed during DECODE -> ignored.
REQ-039 reset=0 asserted mid-WB -> rf_write drops to 0 immediately, the write does not occur, and pc=0 and retired=0.
